// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// Holds the FSM state encoding, the default operand width and the counter sizing helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;

  // A one-bit counter is kept even for degenerate widths so the vector never collapses.
  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_bits(DEF_WIDTH);

endpackage

// File: rtl/mul_addstep.sv
// One shift-add iteration: conditional WIDTH+1-bit add into the accumulator upper half,
// then a 1-bit right shift of {carry, acc, mplier}.
module mul_addstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mplier_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gate
      assign addend[gi] = mcand[gi] & mplier[0];
    end
  endgenerate

  assign sum = {1'b0, acc} + {1'b0, addend};

  // The carry drops into the accumulator MSB and the sum LSB enters the multiplier register.
  assign acc_next    = sum[WIDTH:1];
  assign mplier_next = {sum[0], mplier[WIDTH-1:1]};

endmodule

// File: rtl/seq_mul.sv
// Iterative signed/unsigned multiplier: magnitudes are multiplied over WIDTH RUN cycles,
// and the sign is applied when the product is loaded into p.
module seq_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int CW = (WIDTH == DEF_WIDTH) ? CNT_W : cnt_bits(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   mcand_reg, mplier_reg, acc_reg;
  logic [WIDTH-1:0]   acc_step, mplier_step;
  logic               neg_reg;
  logic [2*WIDTH-1:0] p_reg, prod;
  logic               a_neg, b_neg, last;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // The most negative value maps onto its unsigned magnitude 2^(WIDTH-1) without overflow.
  assign a_neg = signed_op & a[WIDTH-1];
  assign b_neg = signed_op & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;
  assign last  = (cnt_reg == CNT_LAST);

  mul_addstep #(.WIDTH(WIDTH)) u_addstep (
    .acc         (acc_reg),
    .mcand       (mcand_reg),
    .mplier      (mplier_reg),
    .acc_next    (acc_step),
    .mplier_next (mplier_step)
  );

  assign prod = {acc_step, mplier_step};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      neg_reg    <= 1'b0;
      p_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg  <= a_mag;
            mplier_reg <= b_mag;
            neg_reg    <= a_neg ^ b_neg;
            acc_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        RUN: begin
          acc_reg    <= acc_step;
          mplier_reg <= mplier_step;
          cnt_reg    <= cnt_reg + CW'(1);
          // The final step's result goes straight to p so it is valid during FIN.
          if (last) p_reg <= neg_reg ? (~prod + (2*WIDTH)'(1)) : prod;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == FIN);
  assign p    = p_reg;

endmodule

// File: doc/seq_mul.md
SEQ_MUL -- requirements
Module: seq_mul

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; the product width is 2*WIDTH.
REQ-002 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 Port: rst, input, 1, asynchronous active-high reset.
REQ-004 Port: start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-005 Port: signed_op, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 Port: a, input, WIDTH, multiplicand; sampled with start.
REQ-007 Port: b, input, WIDTH, multiplier; sampled with start.
REQ-008 Port: busy, output, 1, high while a multiply is in progress (RUN or FIN).
REQ-009 Port: done, output, 1, single-cycle pulse marking p valid.
REQ-010 Port: p, output, 2*WIDTH, product register; holds its value until the next done.

Function
REQ-011 The block shall be an iterative shift-add multiplier that feeds one WIDTH+1-bit addition per cycle; it is the issue stage in front of the adder datapath.
REQ-012 The FSM states shall be IDLE, RUN and FIN: IDLE->RUN on start; RUN->FIN when the iteration count reaches WIDTH-1; FIN->IDLE unconditionally.
REQ-013 The start edge in IDLE shall capture |a| and |b| (unsigned values when signed_op=0), the sign flag neg = signed_op & (a[MSB]^b[MSB]), and clear the accumulator and the counter.
REQ-014 Each RUN cycle: if multiplier LSB=1, add multiplicand to accumulator upper half (WIDTH+1-bit sum, carry kept); then shift {carry,acc,mplier} right 1; counter +1.
REQ-015 RUN shall last exactly WIDTH cycles.
REQ-016 FIN shall load p with the accumulator, two's-complement negated over 2*WIDTH bits when neg=1, and assert done for that one cycle.
REQ-017 Latency: done shall be high in the cycle following edge WIDTH+1 counted from the start-capture edge (33 cycles for WIDTH=32).
REQ-018 busy shall rise the cycle after start capture and fall in the same cycle done falls.
REQ-019 While busy=1, start shall be ignored and a, b and signed_op changes shall not affect the in-flight result.
REQ-020 A start present in the cycle immediately after done (IDLE) shall be accepted, giving back-to-back issue at one result per WIDTH+2 cycles.
REQ-021 The magnitude of signed minimum (0x8000_0000) shall be taken as unsigned 2^(WIDTH-1), with no overflow.
REQ-022 The product shall be exact for all operand pairs; no saturation and no overflow flag.

Reset
REQ-023 Asserting rst shall immediately force state=IDLE, busy=0, done=0, p=0, counter=0, and clear the accumulator, independent of clk.
REQ-024 Reset mid-operation shall abandon the multiply with no done pulse; the first start after rst deasserts shall run normally.

Structure
REQ-025 Package mul_pkg shall hold the state enumeration (IDLE/RUN/FIN), the default WIDTH constant, and the counter width constant $clog2(WIDTH).
REQ-026 One sub-module, mul_addstep, shall perform the combinational WIDTH+1-bit conditional add and the 1-bit right shift; the FSM, counter and registers stay in seq_mul.
REQ-027 The RTL shall not use the behavioural * operator.

Verification
REQ-028 Unsigned 3 x 5, start at cycle 0 -> done exactly at cycle 33, p=0x0000_0000_0000_000F, busy high cycles 1-33.
REQ-029 Signed -7 x 6 -> p=0xFFFF_FFFF_FFFF_FFD6; signed 0x8000_0000 x 0x8000_0000 -> p=0x4000_0000_0000_0000.
REQ-030 Unsigned 0xFFFF_FFFF x 0xFFFF_FFFF -> p=0xFFFF_FFFE_0000_0001; the same operands signed -> p=0x0000_0000_0000_0001.
REQ-031 Start 2 x 2, then pulse start with 9 x 9 at cycle 10 -> single done at cycle 33 with p=4, no second done.
REQ-032 Assert rst at cycle 15 of a multiply -> busy, done and p go to 0 asynchronously; a new 4 x 4 issued after release -> p=16 after 33 cycles.
REQ-033 Back-to-back: start held high continuously with 1 x 1 then 2 x 3 -> done pulses 34 cycles apart, p=1 then p=6.
